// File: rtl/paddle_ball_pkg.sv
// Shared types for the paddle-and-ball game core: game state and signed ball direction.
package paddle_ball_pkg;

   typedef enum logic [1:0] {
      HELD = 2'd0,
      FLY  = 2'd1,
      OVER = 2'd2
   } state_t;

   typedef logic signed [1:0] dir_t;

   localparam dir_t DIR_NEG  = -2'sd1;
   localparam dir_t DIR_ZERO = 2'sd0;
   localparam dir_t DIR_POS  = 2'sd1;

endpackage

// File: rtl/tick_div.sv
// Free-running divider producing a one-cycle strobe every `period` clocks.
// The period is compared live, so a change made on a strobe edge applies to the next interval.
module tick_div #(
   parameter  int DIV = 4,
   localparam int W   = $clog2(DIV + 1)
) (
   input  logic         CLK,
   input  logic         rst_n,
   input  logic [W-1:0] period,
   output logic         tick
);

   logic [W-1:0] cnt;

   assign tick = (cnt >= period - W'(1));

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n)    cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/paddle_ball_engine.sv
// Paddle-and-ball game core with column-scanned red/green NxN matrix driver.
// Optional macro PADDLE_SPEEDUP_EN: each paddle hit shortens the ball step period.
module paddle_ball_engine
   import paddle_ball_pkg::*;
#(
   parameter int N        = 8,
   parameter int PAD_W    = 3,
   parameter int SCAN_DIV = 25000,
   parameter int BTN_DIV  = 2500000,
   parameter int BALL_DIV = 5000000,
   parameter int LIVES    = 3
) (
   input  logic                 CLK,
   input  logic                 rst_n,
   input  logic                 left,
   input  logic                 right,
   input  logic                 launch,
   output logic [$clog2(N)-1:0] row_sel,
   output logic [N-1:0]         red_n,
   output logic [N-1:0]         green_n,
   output logic [2:0]           lives_left,
   output logic [15:0]          score,
   output logic                 game_over
);

   localparam int XW   = $clog2(N);
   localparam int PW   = $clog2(BALL_DIV + 1);
   localparam int SCW  = $clog2(SCAN_DIV + 1);
   localparam int BTW  = $clog2(BTN_DIV + 1);
   localparam logic [XW-1:0] PAD_RST_X  = XW'((N - PAD_W) / 2);
   localparam logic [XW-1:0] PAD_MAX_X  = XW'(N - PAD_W);
   localparam logic [XW-1:0] PAD_LAST   = XW'(PAD_W - 1);
   localparam logic [XW-1:0] HALF_X     = XW'(PAD_W / 2);
   localparam logic [XW-1:0] BALL_RST_X = XW'((N - PAD_W) / 2 + PAD_W / 2);
   localparam logic [XW-1:0] X_MAX      = XW'(N - 1);
   localparam logic [XW-1:0] Y_PCHK     = XW'(N - 2);
   localparam logic [2:0]    LIVES_INIT = 3'(LIVES);
   localparam logic [PW-1:0] PERIOD_RST = PW'(BALL_DIV);
`ifdef PADDLE_SPEEDUP_EN
   localparam bit SPEEDUP = 1'b1;
`else
   localparam bit SPEEDUP = 1'b0;
`endif

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [PW-1:0] faster(input logic [PW-1:0] p);
      logic [PW-1:0] dec, floor_p;
      dec     = PW'(BALL_DIV / 8);
      floor_p = PW'(BALL_DIV / 2);
      return (p >= floor_p + dec) ? p - dec : floor_p;
   endfunction

   function automatic logic [XW-1:0] step(input dir_t d);
      return {{(XW-1){d[1]}}, d[0]};
   endfunction

   state_t        state, state_nxt;
   logic [XW-1:0] pad_x, pad_nxt, bx, by, row_nxt;
   dir_t          dx, dy, fdx, fdy, launch_dx;
   logic [PW-1:0] ball_period;
   logic          scan_tick, btn_tick, ball_tick;
   logic          hit, miss, restart, pad_on, ball_on;

   tick_div #(.DIV(SCAN_DIV)) u_scan_div (
      .CLK(CLK), .rst_n(rst_n), .period(SCW'(SCAN_DIV)), .tick(scan_tick));
   tick_div #(.DIV(BTN_DIV)) u_btn_div (
      .CLK(CLK), .rst_n(rst_n), .period(BTW'(BTN_DIV)), .tick(btn_tick));
   tick_div #(.DIV(BALL_DIV)) u_ball_div (
      .CLK(CLK), .rst_n(rst_n), .period(ball_period), .tick(ball_tick));

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) state <= HELD;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (ball_tick) begin
         case (state)
            HELD:    if (launch) state_nxt = FLY;
            FLY:     if (miss) state_nxt = (lives_left == 3'd1) ? OVER : HELD;
            OVER:    if (launch) state_nxt = HELD;
            default: state_nxt = HELD;
         endcase
      end
   end

   always_comb game_over = (state == OVER);

   assign restart   = ball_tick && (state == OVER) && launch;
   assign launch_dx = (left && !right) ? DIR_NEG : ((right && !left) ? DIR_POS : DIR_ZERO);

   always_comb begin
      pad_nxt = pad_x;
      if (btn_tick) begin
         if (left && !right && pad_x != '0)             pad_nxt = pad_x - XW'(1);
         else if (right && !left && pad_x != PAD_MAX_X) pad_nxt = pad_x + XW'(1);
      end
   end

   // Flight rules evaluated on the pre-edge paddle; a deflection into a touching wall is reflected
   always_comb begin
      fdx  = dx;
      fdy  = dy;
      hit  = 1'b0;
      miss = 1'b0;
      if (dx == DIR_NEG && bx == '0)         fdx = DIR_POS;
      else if (dx == DIR_POS && bx == X_MAX) fdx = DIR_NEG;
      if (dy == DIR_NEG && by == '0)         fdy = DIR_POS;
      if (fdy == DIR_POS && by == Y_PCHK) begin
         if (bx >= pad_x && bx <= pad_x + PAD_LAST) begin
            hit = 1'b1;
            fdy = DIR_NEG;
            if (bx == pad_x)                 fdx = (bx == '0) ? DIR_POS : DIR_NEG;
            else if (bx == pad_x + PAD_LAST) fdx = (bx == X_MAX) ? DIR_NEG : DIR_POS;
         end else begin
            miss = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n || restart) begin
         pad_x       <= PAD_RST_X;
         bx          <= BALL_RST_X;
         by          <= Y_PCHK;
         dx          <= DIR_ZERO;
         dy          <= DIR_NEG;
         lives_left  <= LIVES_INIT;
         score       <= '0;
         ball_period <= PERIOD_RST;
      end else begin
         pad_x <= pad_nxt;
         if (state == HELD) begin
            if (ball_tick && launch) begin
               dx <= launch_dx;
               dy <= DIR_NEG;
            end else begin
               bx <= pad_nxt + HALF_X;
               by <= Y_PCHK;
            end
         end else if (state == FLY && ball_tick) begin
            if (miss) begin
               lives_left  <= lives_left - 3'd1;
               bx          <= pad_nxt + HALF_X;
               by          <= Y_PCHK;
               dx          <= DIR_ZERO;
               dy          <= DIR_NEG;
               ball_period <= PERIOD_RST;
            end else begin
               bx <= bx + step(fdx);
               by <= by + step(fdy);
               dx <= fdx;
               dy <= fdy;
               if (hit) begin
                  score <= sat_inc(score);
                  if (SPEEDUP) ball_period <= faster(ball_period);
               end
            end
         end
      end
   end

   assign row_nxt = (row_sel == X_MAX) ? '0 : row_sel + XW'(1);
   assign pad_on  = (row_nxt >= pad_x) && (row_nxt <= pad_x + PAD_LAST);
   assign ball_on = (row_nxt == bx) && (state != OVER);

   // Display column registers, refreshed only on scan steps
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         row_sel <= '0;
         red_n   <= '1;
         green_n <= '1;
      end else if (scan_tick) begin
         row_sel <= row_nxt;
         red_n   <= {~pad_on, {(N-1){1'b1}}};
         green_n <= ball_on ? ~({{(N-1){1'b0}}, 1'b1} << by) : '1;
      end
   end

endmodule

// File: doc/paddle_ball_engine.md
Name: paddle_ball_engine

Overview:
Parametrised paddle-and-ball game core with an integrated column-scanned LED matrix driver for an NxN red/green display. It owns the paddle position, ball motion and bounce physics, the lives and score counters and the game state machine. All timing comes from single-cycle enable strobes in the CLK domain; no derived clocks. It replaces the fixed 8x8 paddle and display logic at the top level.

Parameters:
N, 8, matrix dimension (columns = rows); N >= 4, power of two
PAD_W, 3, paddle width in cells; odd, < N
SCAN_DIV, 25000, CLK cycles per column-scan step
BTN_DIV, 2500000, CLK cycles per paddle-move sample
BALL_DIV, 5000000, CLK cycles per ball step (reset period)
LIVES, 3, lives per game, 1..7

Ports:
CLK  in  1  system clock
rst_n  in  1  asynchronous active-low reset
left  in  1  move paddle left; also selects launch direction
right  in  1  move paddle right; also selects launch direction
launch  in  1  level; releases the ball, or restarts after game over
row_sel  out  log2(N)  column currently driven
red_n  out  N  active-low red pixels of the column; bit y, y=0 is top
green_n  out  N  active-low green pixels of the column
lives_left  out  3  remaining lives
score  out  16  paddle hits, saturating at 16'hFFFF
game_over  out  1  high in OVER state

Behaviour:
- Tick strobes: internal counters pulse scan_tick, btn_tick and ball_tick for 1 cycle every SCAN_DIV, BTN_DIV and ball_period cycles. All counters are 0 on reset.
- Coordinates: paddle occupies y=N-1, x in [pad_x, pad_x+PAD_W-1]. Ball is (bx, by) with dx in {-1,0,+1} and dy in {-1,+1}.
- Reset values:
  - state HELD, pad_x=(N-PAD_W)/2, lives=LIVES, score=0, dy=-1, dx=0, ball_period=BALL_DIV.
  - Outputs: row_sel=0, red_n=all 1, green_n=all 1, game_over=0.
- Paddle, on btn_tick: left only and pad_x>0 -> decrement; right only and pad_x<N-PAD_W -> increment; both or neither -> hold. The paddle moves in every state.
- HELD:
  - Ball sits at (pad_x+PAD_W/2, N-2) and tracks the paddle.
  - On ball_tick with launch=1: go to FLY with dy=-1; dx=-1 if left only, +1 if right only, else 0.
- FLY, on each ball_tick, in this order:
  1. X reflect: dx=-1 at bx=0 -> dx=+1; dx=+1 at bx=N-1 -> dx=-1.
  2. Y top: dy=-1 at by=0 -> dy=+1.
  3. Paddle check, only when dy=+1 and by=N-2:
     - Hit (pad_x <= bx <= pad_x+PAD_W-1): dy=-1; dx=-1 on the leftmost cell, +1 on the rightmost cell, unchanged otherwise; score+1.
     - Miss: lives-1; go to OVER if lives reaches 0, else HELD. No motion this tick.
  4. Move: bx+=dx, by+=dy.
- OVER: game_over=1, ball not drawn. ball_tick with launch=1 restores the reset values of state, pad_x, lives, score, dx, dy and ball_period, except that the scan counter and the tick counters continue.
- Scan, on scan_tick: col = (col==N-1) ? 0 : col+1. Outputs are registered on the same edge from the new col:
  - red_n: bit N-1 low iff col is in the paddle range.
  - green_n: bit by low iff col==bx and state != OVER.
  - row_sel = col.
- A game-state update on a given edge appears no later than the next scan_tick.
- Simultaneous btn_tick and ball_tick: the paddle check uses the pre-update pad_x.
- Asynchronous reset mid-game returns everything to reset values immediately.

Optional Feature:
PADDLE_SPEEDUP_EN
- Defined: each paddle hit reduces ball_period by BALL_DIV/8, floored at BALL_DIV/2. A lost life or a restart reloads BALL_DIV. The ball counter compares against ball_period, and a new period takes effect at the next wrap.
- Undefined: ball_period is constant at BALL_DIV.

Decomposition:
- Package paddle_ball_pkg: state enum (HELD, FLY, OVER), 2-bit signed direction type, DIR_NEG/DIR_ZERO/DIR_POS constants.
- Sub-module tick_div:
  - Parameter DIV; inputs CLK, rst_n and a period input.
  - Output is a 1-cycle strobe.
  - Instantiated three times.

Test Plan:
(Parameters for all scenarios: N=8, PAD_W=3, SCAN_DIV=2, BTN_DIV=4, BALL_DIV=8.)
- Reset and display: after reset, over 8 scans, red_n=8'h7F on cols 2..4 and 8'hFF elsewhere; green_n=8'hBF on col 3; lives_left=3, score=0.
- Paddle clamp: right held for 10 btn_ticks -> pad_x=5; left held for 10 -> pad_x=0; both held -> pad_x unchanged.
- Straight launch: launch with no direction at pad_x=2 -> by=5..0 over 6 ball_ticks; 7th tick by=1 with dy=+1; bx stays 3.
- Wall bounce: launch with right from pad_x=5 (ball x=6) -> bx=7, then bx=6 with dx=-1.
- Paddle hit:
  - Ball descending at (2,6) with pad_x=2 -> score=1, dy=-1, dx=-1, next position (1,5).
  - Same with SPEEDUP_EN defined -> ball_period=7.
- Miss and game over:
  - Move the paddle away from a descending ball three times -> lives 2, 1, then game_over=1 and green_n=8'hFF on all columns.
  - launch -> lives_left=3, score=0, state HELD.
